// File: rtl/elliptic_curve_structs.sv
// rtl/elliptic_curve_structs.sv - shared point type, sequencer states and infinity flag encoding
// Purpose: common types for the scalar-multiplication controller and the point units.
// Contents:
//   curve_point_t   affine point, 256-bit x and y coordinates
//   POINT_INF_FLAG  value of an infinity flag meaning "point at infinity"
//   ctrl_state_t    point_mult_ctrl sequencer states
package elliptic_curve_structs;

   localparam int COORD_W = 256;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } curve_point_t;

   localparam logic POINT_INF_FLAG = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DBL_GO,
      ST_DBL_WAIT,
      ST_ADD_GO,
      ST_ADD_WAIT,
      ST_FINISH
   } ctrl_state_t;

endpackage

// File: rtl/unit_launcher.sv
// rtl/unit_launcher.sv - Reset/Done handshake for one external point unit
// Purpose: keeps the unit in reset while idle, releases it after a launch request and
// returns a one-cycle finished strobe. Done in the first released cycle is ignored because
// it may still be left over from the previous operation.
// Ports:
//   clk, i_rst     clock, asynchronous active-high reset
//   i_go           launch request (one cycle, unit is still held in reset during it)
//   i_done         unit Done
//   o_unit_reset   reset to the unit
//   o_finished     one-cycle strobe: unit result is valid this cycle
module unit_launcher (
   input  logic clk,
   input  logic i_rst,
   input  logic i_go,
   input  logic i_done,
   output logic o_unit_reset,
   output logic o_finished
);

   logic r_active;
   logic r_first;

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_active <= 1'b0;
         r_first  <= 1'b0;
      end else if (i_go) begin
         r_active <= 1'b1;
         r_first  <= 1'b1;
      end else begin
         r_first <= 1'b0;
         if (o_finished) begin
            r_active <= 1'b0;
         end
      end
   end

   assign o_unit_reset = ~r_active;
   assign o_finished   = r_active & ~r_first & i_done;

endmodule

// File: rtl/point_mult_ctrl.sv
// rtl/point_mult_ctrl.sv - MSB-first double-and-add scalar multiplication sequencer
// Purpose: computes R = k*P using one external point_double and one external point_add
// unit. Unit operands are registered and held for the whole unit operation since the
// units read them combinationally.
// Build option POINT_MULT_CONST_TIME_EN: every bit runs one double and one add (dummy
// work on p_reg while the accumulator is at infinity); results are committed only where
// the key bit asks for them, so start-to-done time does not depend on k.
// Ports:
//   clk, Reset             clock, asynchronous active-high reset
//   start, k, P            one-cycle request, scalar, base point (accepted in IDLE only)
//   busy, done             operation in progress, one-cycle completion pulse
//   R, R_inf               result and infinity flag, held until the next result
//   dbl_reset, dbl_P       point_double reset and operand
//   dbl_done, dbl_R        point_double completion and result
//   add_reset, add_P/Q     point_add reset and operands
//   add_done, add_R        point_add completion and result
module point_mult_ctrl
   import elliptic_curve_structs::*;
#(
   parameter int KEY_WIDTH = 256,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 Reset,
   input  logic                 start,
   input  logic [KEY_WIDTH-1:0] k,
   input  curve_point_t         P,
   output logic                 busy,
   output logic                 done,
   output curve_point_t         R,
   output logic                 R_inf,
   output logic                 dbl_reset,
   output curve_point_t         dbl_P,
   input  logic                 dbl_done,
   input  curve_point_t         dbl_R,
   output logic                 add_reset,
   output curve_point_t         add_P,
   output curve_point_t         add_Q,
   input  logic                 add_done,
   input  curve_point_t         add_R
);

   ctrl_state_t          r_state, w_state_nxt, w_state_adv;
   logic [KEY_WIDTH-1:0] r_k, w_k_nxt;
   curve_point_t         r_p, w_p_nxt, r_acc, w_acc_nxt, r_res, w_res_nxt;
   curve_point_t         r_dbl_p, w_dbl_p_nxt, r_add_p, w_add_p_nxt, r_add_q, w_add_q_nxt;
   logic                 r_acc_inf, w_acc_inf_nxt, r_pend, w_pend_nxt;
   logic                 r_res_inf, w_res_inf_nxt, r_done, w_done_nxt, r_busy, w_busy_nxt;
   logic [CNT_W-1:0]     r_idx, w_idx_nxt, w_idx_adv;
   logic                 w_bit, w_last, w_x_eq, w_y_eq;
   logic                 w_dbl_go, w_add_go, w_dbl_fin, w_add_fin;

   assign w_bit  = r_k[r_idx];
   assign w_last = (r_idx == '0);
   assign w_x_eq = (r_acc.x == r_p.x);
   assign w_y_eq = (r_acc.y == r_p.y);

   // Common "bit finished" step: stop after bit 0, otherwise double for the next bit.
   assign w_state_adv = w_last ? ST_FINISH : ST_DBL_GO;
   assign w_idx_adv   = w_last ? r_idx : r_idx - CNT_W'(1);

   unit_launcher u_dbl (
      .clk          (clk),
      .i_rst        (Reset),
      .i_go         (w_dbl_go),
      .i_done       (dbl_done),
      .o_unit_reset (dbl_reset),
      .o_finished   (w_dbl_fin)
   );

   unit_launcher u_add (
      .clk          (clk),
      .i_rst        (Reset),
      .i_go         (w_add_go),
      .i_done       (add_done),
      .o_unit_reset (add_reset),
      .o_finished   (w_add_fin)
   );

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_state   <= ST_IDLE;
         r_k       <= '0;
         r_p       <= '0;
         r_acc     <= '0;
         r_acc_inf <= POINT_INF_FLAG;
         r_idx     <= '0;
         r_pend    <= 1'b0;
         r_dbl_p   <= '0;
         r_add_p   <= '0;
         r_add_q   <= '0;
         r_res     <= '0;
         r_res_inf <= POINT_INF_FLAG;
         r_done    <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_k       <= w_k_nxt;
         r_p       <= w_p_nxt;
         r_acc     <= w_acc_nxt;
         r_acc_inf <= w_acc_inf_nxt;
         r_idx     <= w_idx_nxt;
         r_pend    <= w_pend_nxt;
         r_dbl_p   <= w_dbl_p_nxt;
         r_add_p   <= w_add_p_nxt;
         r_add_q   <= w_add_q_nxt;
         r_res     <= w_res_nxt;
         r_res_inf <= w_res_inf_nxt;
         r_done    <= w_done_nxt;
         r_busy    <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_k_nxt       = r_k;
      w_p_nxt       = r_p;
      w_acc_nxt     = r_acc;
      w_acc_inf_nxt = r_acc_inf;
      w_idx_nxt     = r_idx;
      w_pend_nxt    = r_pend;
      w_dbl_p_nxt   = r_dbl_p;
      w_add_p_nxt   = r_add_p;
      w_add_q_nxt   = r_add_q;
      w_res_nxt     = r_res;
      w_res_inf_nxt = r_res_inf;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_dbl_go      = 1'b0;
      w_add_go      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_k_nxt       = k;
               w_p_nxt       = P;
               w_acc_inf_nxt = POINT_INF_FLAG;
               w_idx_nxt     = CNT_W'(KEY_WIDTH - 1);
               w_pend_nxt    = 1'b0;
               w_busy_nxt    = 1'b1;
               w_state_nxt   = ST_SCAN;
            end
         end
         ST_SCAN: begin
`ifdef POINT_MULT_CONST_TIME_EN
            w_state_nxt = ST_DBL_GO;
`else
            // Accumulator is at infinity here: skip zeros, load P on the first set bit.
            if (w_bit) begin
               w_acc_nxt     = r_p;
               w_acc_inf_nxt = ~POINT_INF_FLAG;
               w_state_nxt   = w_state_adv;
               w_idx_nxt     = w_idx_adv;
            end else if (w_last) begin
               w_state_nxt = ST_FINISH;
            end else begin
               w_idx_nxt = r_idx - CNT_W'(1);
            end
`endif
         end
         ST_DBL_GO: begin
            w_dbl_go = 1'b1;
`ifdef POINT_MULT_CONST_TIME_EN
            w_dbl_p_nxt = r_acc_inf ? r_p : r_acc;
`else
            w_dbl_p_nxt = r_acc;
`endif
            w_state_nxt = ST_DBL_WAIT;
         end
         ST_DBL_WAIT: begin
            if (w_dbl_fin) begin
               if (r_pend) begin
                  // This double stood in for acc+P with acc==P; the bit is already done.
                  w_acc_nxt   = dbl_R;
                  w_pend_nxt  = 1'b0;
                  w_state_nxt = w_state_adv;
                  w_idx_nxt   = w_idx_adv;
               end else begin
`ifdef POINT_MULT_CONST_TIME_EN
                  if (r_acc_inf != POINT_INF_FLAG) begin
                     w_acc_nxt = dbl_R;
                  end
                  w_state_nxt = ST_ADD_GO;
`else
                  w_acc_nxt = dbl_R;
                  if (w_bit) begin
                     w_state_nxt = ST_ADD_GO;
                  end else begin
                     w_state_nxt = w_state_adv;
                     w_idx_nxt   = w_idx_adv;
                  end
`endif
               end
            end
         end
         ST_ADD_GO: begin
            w_add_q_nxt = r_p;
`ifdef POINT_MULT_CONST_TIME_EN
            w_add_p_nxt = r_acc_inf ? r_p : r_acc;
            if (r_acc_inf != POINT_INF_FLAG && w_bit && w_x_eq && w_y_eq) begin
               w_dbl_p_nxt = r_acc;
               w_pend_nxt  = 1'b1;
               w_state_nxt = ST_DBL_GO;
            end else begin
               w_add_go    = 1'b1;
               w_state_nxt = ST_ADD_WAIT;
            end
`else
            w_add_p_nxt = r_acc;
            if (w_x_eq && w_y_eq) begin
               w_dbl_p_nxt = r_acc;
               w_pend_nxt  = 1'b1;
               w_state_nxt = ST_DBL_GO;
            end else if (w_x_eq) begin
               // acc == -P: the sum is infinity; SCAN resumes from the next bit.
               w_acc_inf_nxt = POINT_INF_FLAG;
               w_idx_nxt     = w_idx_adv;
               w_state_nxt   = w_last ? ST_FINISH : ST_SCAN;
            end else begin
               w_add_go    = 1'b1;
               w_state_nxt = ST_ADD_WAIT;
            end
`endif
         end
         ST_ADD_WAIT: begin
            if (w_add_fin) begin
`ifdef POINT_MULT_CONST_TIME_EN
               if (w_bit) begin
                  if (r_acc_inf == POINT_INF_FLAG) begin
                     w_acc_nxt     = r_p;
                     w_acc_inf_nxt = ~POINT_INF_FLAG;
                  end else if (w_x_eq) begin
                     w_acc_inf_nxt = POINT_INF_FLAG;
                  end else begin
                     w_acc_nxt = add_R;
                  end
               end
`else
               w_acc_nxt = add_R;
`endif
               w_state_nxt = w_state_adv;
               w_idx_nxt   = w_idx_adv;
            end
         end
         ST_FINISH: begin
            w_res_nxt     = r_acc;
            w_res_inf_nxt = r_acc_inf;
            w_done_nxt    = 1'b1;
            w_busy_nxt    = 1'b0;
            w_state_nxt   = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign busy  = r_busy;
   assign done  = r_done;
   assign R     = r_res;
   assign R_inf = r_res_inf;
   assign dbl_P = r_dbl_p;
   assign add_P = r_add_p;
   assign add_Q = r_add_q;

endmodule

// File: tb/tb_point_mult_ctrl.sv
// tb/tb_point_mult_ctrl.sv - directed bench for point_mult_ctrl on y^2=x^3+7 mod 17, P=(15,13)
module tb_point_mult_ctrl;
   import elliptic_curve_structs::*;

   localparam int KW     = 256;
   localparam int LAT    = 6;
   localparam int MAXCYC = 20000;

   logic          clk = 1'b0;
   logic          Reset;
   logic          start;
   logic [KW-1:0] k;
   curve_point_t  P;
   logic          busy, done, R_inf, dbl_reset, add_reset;
   logic          dbl_done = 1'b0;
   logic          add_done = 1'b0;
   curve_point_t  R, dbl_P, add_P, add_Q;
   curve_point_t  dbl_R = '0;
   curve_point_t  add_R = '0;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_dbl    = 0;
   int   n_add    = 0;
   int   dcnt     = 0;
   int   acnt     = 0;
   logic dr_q     = 1'b1;
   logic ar_q     = 1'b1;

   always #5 clk = ~clk;

   point_mult_ctrl #(.KEY_WIDTH(KW), .CNT_W(8)) dut (
      .clk       (clk),
      .Reset     (Reset),
      .start     (start),
      .k         (k),
      .P         (P),
      .busy      (busy),
      .done      (done),
      .R         (R),
      .R_inf     (R_inf),
      .dbl_reset (dbl_reset),
      .dbl_P     (dbl_P),
      .dbl_done  (dbl_done),
      .dbl_R     (dbl_R),
      .add_reset (add_reset),
      .add_P     (add_P),
      .add_Q     (add_Q),
      .add_done  (add_done),
      .add_R     (add_R)
   );

   function automatic int md(int a);
      return ((a % 17) + 17) % 17;
   endfunction

   function automatic int inv17(int a);
      int r = 0;
      for (int i = 1; i < 17; i++) if (md(a * i) == 1) r = i;
      return r;
   endfunction

   function automatic curve_point_t mkpt(int x, int y);
      curve_point_t p;
      p.x = 256'(x);
      p.y = 256'(y);
      return p;
   endfunction

   function automatic curve_point_t m_double(curve_point_t a);
      int xa  = md(int'(a.x[15:0]));
      int ya  = md(int'(a.y[15:0]));
      int lam = md(3 * xa * xa * inv17(md(2 * ya)));
      int x3  = md(lam * lam - 2 * xa);
      return mkpt(x3, md(lam * (xa - x3) - ya));
   endfunction

   function automatic curve_point_t m_add(curve_point_t a, curve_point_t b);
      int xa  = md(int'(a.x[15:0]));
      int ya  = md(int'(a.y[15:0]));
      int xb  = md(int'(b.x[15:0]));
      int yb  = md(int'(b.y[15:0]));
      int lam = md((yb - ya) * inv17(md(xb - xa)));
      int x3  = md(lam * lam - xa - xb);
      return mkpt(x3, md(lam * (xa - x3) - ya));
   endfunction

   // Stub units: fixed latency after reset release, Done held until reset returns.
   always @(posedge clk) begin
      dr_q <= dbl_reset;
      ar_q <= add_reset;
      if (dr_q && !dbl_reset) n_dbl <= n_dbl + 1;
      if (ar_q && !add_reset) n_add <= n_add + 1;
      if (dbl_reset) begin
         dcnt     <= 0;
         dbl_done <= 1'b0;
      end else if (dcnt < LAT) begin
         dcnt <= dcnt + 1;
         if (dcnt == LAT - 1) begin
            dbl_done <= 1'b1;
            dbl_R    <= m_double(dbl_P);
         end
      end
      if (add_reset) begin
         acnt     <= 0;
         add_done <= 1'b0;
      end else if (acnt < LAT) begin
         acnt <= acnt + 1;
         if (acnt == LAT - 1) begin
            add_done <= 1'b1;
            add_R    <= m_add(add_P, add_Q);
         end
      end
   end

   task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < MAXCYC) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check_eq("no_timeout", cyc < MAXCYC, 1'b1);
   endtask

   task automatic run_mult(input logic [KW-1:0] kv, output int cyc, output int nd, output int na);
      int d0, a0;
      @(negedge clk);
      k     = kv;
      P     = mkpt(15, 13);
      start = 1'b1;
      d0    = n_dbl;
      a0    = n_add;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(cyc);
      nd = n_dbl - d0;
      na = n_add - a0;
   endtask

   int            cyc, nd, na, c1, c3, w;
   logic [KW-1:0] kbig;

   initial begin
      Reset = 1'b1;
      start = 1'b0;
      k     = '0;
      P     = '0;
      #12;
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_R", R, '0);
      check_eq("rst_R_inf", R_inf, 1'b1);
      check_eq("rst_dbl_reset", dbl_reset, 1'b1);
      check_eq("rst_add_reset", add_reset, 1'b1);
      check_eq("rst_operands", {dbl_P, add_P, add_Q} == '0, 1'b1);
      @(negedge clk);
      Reset = 1'b0;

      run_mult('0, cyc, nd, na);
      check_eq("k0_R_inf", R_inf, 1'b1);
`ifndef POINT_MULT_CONST_TIME_EN
      check_eq("k0_latency", cyc, KW + 1);
      check_eq("k0_dbl_ops", nd, 0);
      check_eq("k0_add_ops", na, 0);
`endif

      run_mult(KW'(1), cyc, nd, na);
      check_eq("k1_R", R, mkpt(15, 13));
      check_eq("k1_R_inf", R_inf, 1'b0);
      check_eq("k1_busy_at_done", busy, 1'b0);
`ifndef POINT_MULT_CONST_TIME_EN
      check_eq("k1_dbl_ops", nd, 0);
      check_eq("k1_add_ops", na, 0);
`endif
      @(posedge clk);
      #1;
      check_eq("k1_done_one_cycle", done, 1'b0);

      run_mult(KW'(2), cyc, nd, na);
      check_eq("k2_R", R, mkpt(2, 10));
      check_eq("k2_R_inf", R_inf, 1'b0);
`ifndef POINT_MULT_CONST_TIME_EN
      check_eq("k2_dbl_ops", nd, 1);
      check_eq("k2_add_ops", na, 0);
`endif

      run_mult(KW'(3), cyc, nd, na);
      check_eq("k3_R", R, mkpt(8, 3));
`ifndef POINT_MULT_CONST_TIME_EN
      check_eq("k3_dbl_ops", nd, 1);
      check_eq("k3_add_ops", na, 1);
`endif

      kbig      = '0;
      kbig[255] = 1'b1;
      run_mult(kbig, cyc, nd, na);
      check_eq("kmsb_R", R, mkpt(1, 12));
      check_eq("kmsb_R_inf", R_inf, 1'b0);
`ifndef POINT_MULT_CONST_TIME_EN
      check_eq("kmsb_dbl_ops", nd, 255);
      check_eq("kmsb_add_ops", na, 0);
`endif

      // A second start while busy must be ignored.
      @(negedge clk);
      k     = KW'(3);
      P     = mkpt(15, 13);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check_eq("busy_after_start", busy, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      k     = KW'(1);
      P     = mkpt(2, 10);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(cyc);
      check_eq("busy_start_R", R, mkpt(8, 3));
      repeat (5) @(posedge clk);
      #1;
      check_eq("R_held", R, mkpt(8, 3));
      check_eq("idle_busy", busy, 1'b0);

      // Reset while the doubler is running.
      @(negedge clk);
      k     = KW'(2);
      P     = mkpt(15, 13);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      w = 0;
      while (dbl_reset !== 1'b0 && w < MAXCYC) begin
         @(posedge clk);
         #1;
         w++;
      end
      check_eq("reach_dbl_wait", w < MAXCYC, 1'b1);
      Reset = 1'b1;
      @(posedge clk);
      #1;
      check_eq("midrst_busy", busy, 1'b0);
      check_eq("midrst_dbl_reset", dbl_reset, 1'b1);
      check_eq("midrst_R_inf", R_inf, 1'b1);
      check_eq("midrst_R", R, '0);
      @(negedge clk);
      Reset = 1'b0;
      run_mult(KW'(3), cyc, nd, na);
      check_eq("after_rst_k3_R", R, mkpt(8, 3));
      check_eq("after_rst_k3_R_inf", R_inf, 1'b0);

`ifdef POINT_MULT_CONST_TIME_EN
      run_mult(KW'(1), c1, nd, na);
      check_eq("ct_k1_R", R, mkpt(15, 13));
      run_mult(KW'(3), c3, nd, na);
      check_eq("ct_k3_R", R, mkpt(8, 3));
      check_eq("ct_equal_cycles", c1, c3);
`else
      c1 = 0;
      c3 = 0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/point_mult_ctrl.md
Name: point_mult_ctrl

Overview:
- Scalar-multiplication sequencer: computes R = k*P by MSB-first double-and-add.
- Drives one external point_double instance and one external point_add instance, each through its Reset/Done interface.
- Sits between the top-level ECC command logic and the point-operation primitives.
- Holds the operand registers stable for the whole of each unit operation, because the units read their inputs combinationally.

Parameters:
- KEY_WIDTH, 256, scalar width in bits.
- CNT_W, 8, bit-index counter width; must satisfy 2^CNT_W >= KEY_WIDTH.

Ports:
- clk  in  1  clock.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- k  in  KEY_WIDTH  scalar; captured on an accepted start.
- P  in  curve_point_t  base point; captured on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when R is valid.
- R  out  curve_point_t  result; held until the next accepted start.
- R_inf  out  1  result is the point at infinity.
- dbl_reset  out  1  reset to the point_double unit.
- dbl_P  out  curve_point_t  point_double operand (registered).
- dbl_done  in  1  point_double Done.
- dbl_R  in  curve_point_t  point_double result.
- add_reset  out  1  reset to the point_add unit.
- add_P, add_Q  out  curve_point_t  point_add operands (registered).
- add_done  in  1  point_add Done.
- add_R  in  curve_point_t  point_add result.

Behaviour:
- Reset values: busy=0, done=0, R=0, R_inf=1, dbl_reset=1, add_reset=1, all operand registers 0, state=IDLE.
- Unit reset rule: each unit is held in reset (dbl_reset/add_reset=1) whenever it is not in use.
- State IDLE:
  - start=1 captures k into k_reg and P into p_reg.
  - Sets acc_inf=1 and idx=KEY_WIDTH-1, then goes to SCAN.
  - start is ignored in every other state.
- State SCAN (one cycle per bit):
  - While acc_inf=1 and k_reg[idx]=0, decrement idx; no unit is used.
  - First set bit: acc=p_reg, acc_inf=0. If idx=0 go to FINISH, else decrement idx and go to DBL_GO.
  - k=0 reaches FINISH with R_inf=1. Latency for k=0 is KEY_WIDTH+1 cycles from start to done.
- State DBL_GO: load dbl_P=acc, drive dbl_reset=1 for exactly one cycle, then go to DBL_WAIT.
- State DBL_WAIT:
  - dbl_reset=0. dbl_done is ignored in the first cycle of DBL_WAIT (stale Done guard).
  - On dbl_done: acc=dbl_R, dbl_reset returns to 1.
  - If k_reg[idx]=1 go to ADD_GO. Otherwise, if idx=0 go to FINISH, else decrement idx and go to DBL_GO.
- State ADD_GO:
  - Load add_P=acc and add_Q=p_reg.
  - If acc.x==p_reg.x and acc.y==p_reg.y: route to the doubler instead (dbl_P=acc, go to DBL_GO with an add_pending_clear flag, so the bit is not re-tested).
  - If acc.x==p_reg.x and acc.y!=p_reg.y: set acc_inf=1 and go to the next bit without using a unit.
  - Otherwise pulse add_reset for one cycle and go to ADD_WAIT.
- State ADD_WAIT: same Done guard as DBL_WAIT. On add_done: acc=add_R. If idx=0 go to FINISH, else decrement idx and go to DBL_GO.
- State FINISH: R=acc, R_inf=acc_inf, done=1 for one cycle, busy=0, return to IDLE.
- Reset mid-operation: returns to IDLE asynchronously. Outputs take their reset values; the units are held in reset.
- All comparisons are full 256-bit equality on coordinates. No modular reduction is performed in this block.

Optional Feature:
- Macro: POINT_MULT_CONST_TIME_EN.
- Defined:
  - Every bit after the first set bit runs both DBL and ADD.
  - The add result is committed only when k_reg[idx]=1.
  - The leading-zero SCAN skip is replaced by a dummy doubling of p_reg per bit.
  - Start-to-done cycle count depends only on KEY_WIDTH and the unit latencies, not on k.
- Undefined: behaviour exactly as specified above.

Decomposition:
- elliptic_curve_structs supplies curve_point_t.
- Add to that package: the state enum ctrl_state_t and the localparam POINT_INF_FLAG encoding.
- One sub-module: unit_launcher, instantiated twice (double and add).
  - Generates the one-cycle reset pulse and the first-cycle Done guard.
  - Returns a single-cycle finished strobe.

Test Plan:
- Bench models: stub double and add units with a fixed 6-cycle latency, using a small-curve reference model (y^2=x^3+7 mod 17, P=(15,13)).
- k=0, start pulse -> done after KEY_WIDTH+1 cycles, R_inf=1, no unit reset ever deasserted.
- k=1 -> R=P, R_inf=0, zero unit operations.
- k=2 -> exactly one double, R matches the model's 2P.
- k=3 -> one double then one add, R=3P.
- k=2^255 -> 255 doubles, no adds, R matches the model.
- start asserted again while busy -> ignored, result unchanged.
- Reset asserted in DBL_WAIT -> next cycle busy=0 and dbl_reset=1; a fresh k=3 then completes correctly.
- With POINT_MULT_CONST_TIME_EN: k=1 and k=3 give identical start-to-done cycle counts.
